// File: rtl/fir_mc_pkg.sv
// fir_mc_pkg: shared widths and state encoding for the multi-channel FIR.
// The width helpers let every file derive the same accumulator, channel-tag and
// tap-address widths from the top-level parameters.
package fir_mc_pkg;

  // Commit sequencer states: accept traffic, drain S1..S3, copy shadow to active.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } coef_state_t;

  // ceil(log2(n)), never below one bit so single-entry tags still have a port.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Accumulator wide enough that NUM_TAPS full-scale products cannot overflow.
  function automatic int acc_w(input int data_w, input int coef_w, input int num_taps);
    return data_w + coef_w + clog2_min1(num_taps);
  endfunction

  // Channel tag width.
  function automatic int ch_w(input int num_channels);
    return clog2_min1(num_channels);
  endfunction

  // Coefficient write address width.
  function automatic int addr_w(input int num_taps);
    return clog2_min1(num_taps);
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat: combinational round-half-up, arithmetic shift and range fit.
// Build option FIR_SATURATION_EN: out-of-range results clamp to the output
// max/min and raise overflow; without it the low OUT_WIDTH bits are kept
// (two's-complement wrap) and overflow is held low.
module fir_round_sat
  import fir_mc_pkg::*;
#(
  parameter int ACC_W     = 38,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_SHIFT = 15
) (
  input  logic signed [ACC_W-1:0]     acc,
  output logic signed [OUT_WIDTH-1:0] result,
  output logic                        overflow
);

  // One extra bit so adding the rounding constant can never wrap.
  localparam int EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] HALF =
    {{(EXT_W-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
  localparam logic signed [EXT_W-1:0] MAX_OUT =
    EXT_W'({1'b0, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [EXT_W-1:0] MIN_OUT = ~MAX_OUT;

  logic signed [EXT_W-1:0] rounded_s;
  logic signed [EXT_W-1:0] shifted_s;

  // Round half up, shift down, then clamp or wrap into the output width.
  always_comb begin
    rounded_s = {acc[ACC_W-1], acc} + HALF;
    shifted_s = rounded_s >>> OUT_SHIFT;
`ifdef FIR_SATURATION_EN
    if (shifted_s > MAX_OUT) begin
      result   = MAX_OUT[OUT_WIDTH-1:0];
      overflow = 1'b1;
    end else if (shifted_s < MIN_OUT) begin
      result   = MIN_OUT[OUT_WIDTH-1:0];
      overflow = 1'b1;
    end else begin
      result   = OUT_WIDTH'(shifted_s);
      overflow = 1'b0;
    end
`else
    result   = OUT_WIDTH'(shifted_s);
    overflow = 1'b0;
`endif
  end

endmodule

// File: rtl/fir_filter_mc.sv
// fir_filter_mc: multi-channel, time-shared transposed FIR with valid/ready
// streaming on both sides and a shadow/active coefficient pair.
// Each channel owns its own transposed-form partial-sum row, so an accepted
// sample only advances its own channel. Pipeline: S1 input register, S2 tap
// products, S3 output sum plus partial-sum update, S4 rounded output register.
// Every stage freezes while the output is held by downstream.
// Build option FIR_SATURATION_EN selects clamping instead of wrapping in the
// output stage (handled inside fir_round_sat).
module fir_filter_mc
  import fir_mc_pkg::*;
#(
  parameter int NUM_TAPS     = 60,
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int COEF_WIDTH   = 16,
  parameter int OUT_WIDTH    = 16,
  parameter int OUT_SHIFT    = 15,
  localparam int CH_W   = ch_w(NUM_CHANNELS),
  localparam int ADDR_W = addr_w(NUM_TAPS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic [CH_W-1:0]              in_channel,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic [CH_W-1:0]              out_channel,
  output logic                         out_overflow,
  input  logic                         coef_wr_en,
  input  logic [ADDR_W-1:0]            coef_wr_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_wr_data,
  input  logic                         coef_commit,
  output logic                         coef_busy
);

  localparam int ACC_W  = acc_w(DATA_WIDTH, COEF_WIDTH, NUM_TAPS);
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;

  // Coefficient banks: host writes shadow, datapath reads active.
  logic signed [COEF_WIDTH-1:0] shadow_coef_r [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] active_coef_r [NUM_TAPS];

  // Commit sequencer.
  coef_state_t state_r;
  coef_state_t state_next_s;
  logic        coef_busy_r;

  // Handshake.
  logic stall_s;
  logic accept_s;
  logic pipe_empty_s;

  // S1: captured sample.
  logic                         s1_valid_r;
  logic signed [DATA_WIDTH-1:0] s1_data_r;
  logic [CH_W-1:0]              s1_ch_r;

  // S2: one product per tap.
  logic                     s2_valid_r;
  logic [CH_W-1:0]          s2_ch_r;
  logic signed [PROD_W-1:0] s2_prod_r [NUM_TAPS];

  // S3: full output sum.
  logic                    s3_valid_r;
  logic [CH_W-1:0]         s3_ch_r;
  logic signed [ACC_W-1:0] s3_acc_r;

  // Partial sums; psum_r[c][j] holds the transposed-form term ps[c][j+1].
  logic signed [ACC_W-1:0] psum_r [NUM_CHANNELS][NUM_TAPS-1];
  logic signed [ACC_W-1:0] y_s;

  // Output-stage combinational result.
  logic signed [OUT_WIDTH-1:0] rs_data_s;
  logic                        rs_ovf_s;

  // Output held by downstream freezes the whole pipe; intake also closes while
  // a coefficient commit is pending.
  assign stall_s      = out_valid && !out_ready;
  assign in_ready     = !stall_s && (state_r == IDLE);
  assign accept_s     = in_valid && in_ready;
  assign pipe_empty_s = !s1_valid_r && !s2_valid_r && !s3_valid_r;
  assign coef_busy    = coef_busy_r;

  // Output sum for the channel in S2, reading the row written on the previous
  // edge so back-to-back samples of one channel see the exact serial state.
  assign y_s = ACC_W'(s2_prod_r[0]) + psum_r[s2_ch_r][0];

  // Shadow bank write port; addresses beyond the last tap are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        shadow_coef_r[k] <= {COEF_WIDTH{1'b0}};
      end
    end else if (coef_wr_en && (int'(coef_wr_addr) < NUM_TAPS)) begin
      shadow_coef_r[coef_wr_addr] <= coef_wr_data;
    end
  end

  // Active bank copies the shadow bank during the single SWAP cycle; a write
  // landing on that same edge reaches shadow only.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        active_coef_r[k] <= {COEF_WIDTH{1'b0}};
      end
    end else if (state_r == SWAP) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        active_coef_r[k] <= shadow_coef_r[k];
      end
    end
  end

  // Commit sequencer state and busy flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      coef_busy_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      coef_busy_r <= (state_next_s != IDLE);
    end
  end

  // Commit sequencer next state; S4 is not part of the drain condition.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (coef_commit) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = IDLE;
        end
      end
      DRAIN: begin
        if (pipe_empty_s) begin
          state_next_s = SWAP;
        end else begin
          state_next_s = DRAIN;
        end
      end
      SWAP: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // S1: capture the accepted sample and its channel tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {DATA_WIDTH{1'b0}};
      s1_ch_r    <= {CH_W{1'b0}};
    end else if (!stall_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_data_r <= in_data;
        s1_ch_r   <= in_channel;
      end
    end
  end

  // S2: multiply the sample by every active coefficient.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      s2_ch_r    <= {CH_W{1'b0}};
      for (int k = 0; k < NUM_TAPS; k++) begin
        s2_prod_r[k] <= {PROD_W{1'b0}};
      end
    end else if (!stall_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_ch_r <= s1_ch_r;
        for (int k = 0; k < NUM_TAPS; k++) begin
          s2_prod_r[k] <= s1_data_r * active_coef_r[k];
        end
      end
    end
  end

  // S3: register the output sum and advance only this channel's partial sums.
  always_ff @(posedge clock) begin
    if (reset) begin
      s3_valid_r <= 1'b0;
      s3_ch_r    <= {CH_W{1'b0}};
      s3_acc_r   <= {ACC_W{1'b0}};
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        for (int j = 0; j < NUM_TAPS - 1; j++) begin
          psum_r[c][j] <= {ACC_W{1'b0}};
        end
      end
    end else if (!stall_s) begin
      s3_valid_r <= s2_valid_r;
      if (s2_valid_r) begin
        s3_ch_r  <= s2_ch_r;
        s3_acc_r <= y_s;
        for (int j = 0; j < NUM_TAPS - 2; j++) begin
          psum_r[s2_ch_r][j] <= ACC_W'(s2_prod_r[j+1]) + psum_r[s2_ch_r][j+1];
        end
        psum_r[s2_ch_r][NUM_TAPS-2] <= ACC_W'(s2_prod_r[NUM_TAPS-1]);
      end
    end
  end

  fir_round_sat #(
    .ACC_W     (ACC_W),
    .OUT_WIDTH (OUT_WIDTH),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_round_sat (
    .acc      (s3_acc_r),
    .result   (rs_data_s),
    .overflow (rs_ovf_s)
  );

  // S4: output registers; data holds its last value while no result is valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_data     <= {OUT_WIDTH{1'b0}};
      out_channel  <= {CH_W{1'b0}};
      out_overflow <= 1'b0;
    end else if (!stall_s) begin
      out_valid <= s3_valid_r;
      if (s3_valid_r) begin
        out_data     <= rs_data_s;
        out_channel  <= s3_ch_r;
        out_overflow <= rs_ovf_s;
      end
    end
  end

endmodule

// File: tb/tb_fir_filter_mc.sv
// tb_fir_filter_mc: directed bench for fir_filter_mc with default parameters
// (60 taps, 4 channels, 16-bit data/coef/out, shift 15). Expected values are
// hand-derived closed forms or constants; FIR_SATURATION_EN selects which
// saturation-test constants apply.
module tb_fir_filter_mc;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic [1:0]         in_channel;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic [1:0]         out_channel;
  logic               out_overflow;
  logic               coef_wr_en;
  logic [5:0]         coef_wr_addr;
  logic signed [15:0] coef_wr_data;
  logic               coef_commit;
  logic               coef_busy;

  int n_total = 0;
  int n_bad   = 0;
  int q_data[$];
  int q_ch[$];
  int q_ovf[$];

  fir_filter_mc dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_channel   (in_channel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_channel  (out_channel),
    .out_overflow (out_overflow),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
    .coef_commit  (coef_commit),
    .coef_busy    (coef_busy)
  );

  always #5 clock = ~clock;

  // Collect every transferred result, sampled mid-cycle.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      q_data.push_back(int'(out_data));
      q_ch.push_back(int'(out_channel));
      q_ovf.push_back(int'(out_overflow));
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input int ch, input int d);
    int n;
    n = 0;
    in_valid   = 1'b1;
    in_data    = 16'(d);
    in_channel = 2'(ch);
    @(negedge clock);
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("send_ready", in_ready, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Pop the next collected result (bounded wait) and compare it.
  task automatic expect_out(input string tag, input int ch, input int data, input int ovf);
    int n;
    n = 0;
    while (q_data.size() == 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (q_data.size() == 0) begin
      chk({tag, "_missing"}, q_data.size(), 1);
    end else begin
      chk({tag, "_data"}, q_data.pop_front(), data);
      chk({tag, "_ch"}, q_ch.pop_front(), ch);
      chk({tag, "_ovf"}, q_ovf.pop_front(), ovf);
    end
  endtask

  // Let the pipe settle and make sure nothing extra came out.
  task automatic expect_no_more(input string tag);
    repeat (8) @(negedge clock);
    chk(tag, q_data.size(), 0);
    @(posedge clock);
    #1;
  endtask

  // Fill the shadow bank: mode 0 -> h[k]=k+1, mode 1 -> all 0x7FFF.
  task automatic load_coefs(input int mode);
    for (int k = 0; k < 60; k++) begin
      coef_wr_en   = 1'b1;
      coef_wr_addr = 6'(k);
      coef_wr_data = (mode == 0) ? 16'(k + 1) : 16'sh7FFF;
      @(posedge clock);
      #1;
    end
    coef_wr_addr = 6'd63;
    coef_wr_data = 16'sh8000;
    @(posedge clock);
    #1;
    coef_wr_en = 1'b0;
  endtask

  // Pulse commit, check the busy/ready response and wait for completion.
  task automatic commit(input string tag);
    int n;
    coef_commit = 1'b1;
    @(posedge clock);
    #1;
    coef_commit = 1'b0;
    @(negedge clock);
    chk({tag, "_busy"}, coef_busy, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    n = 0;
    while (coef_busy && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_busy_clear"}, coef_busy, 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_data      = 16'sd0;
    in_channel   = 2'd0;
    out_ready    = 1'b1;
    coef_wr_en   = 1'b0;
    coef_wr_addr = 6'd0;
    coef_wr_data = 16'sd0;
    coef_commit  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state.
    @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_channel", out_channel, 0);
    chk("rst_out_overflow", out_overflow, 0);
    chk("rst_coef_busy", coef_busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clock);
    #1;

    // Impulse on ch0 with h[k]=k+1: output n = round((n+1)/2) = (n+2)/2.
    load_coefs(0);
    commit("commit0");
    send(0, 16'h4000);
    lat = 0;
    @(negedge clock);
    while (!out_valid && lat < 10) begin
      lat++;
      @(negedge clock);
    end
    chk("latency_idle_cycles", lat, 3);
    @(posedge clock);
    #1;
    for (int n = 1; n < 62; n++) send(0, 0);
    for (int n = 0; n < 62; n++)
      expect_out($sformatf("imp%0d", n), 0, (n < 60) ? (n + 2) / 2 : 0, 0);
    expect_no_more("imp_extra");

    // Channel isolation: ch1 impulse interleaved with ch0 DC 0x1000.
    for (int n = 0; n < 8; n++) begin
      send(1, (n == 0) ? 16'h4000 : 0);
      send(0, 16'h1000);
    end
    for (int n = 0; n < 8; n++) begin
      expect_out($sformatf("iso_ch1_%0d", n), 1, (n + 2) / 2, 0);
      expect_out($sformatf("iso_ch0_%0d", n), 0, ((n + 1) * (n + 2) / 2 + 4) / 8, 0);
    end
    expect_no_more("iso_extra");

    // Backpressure: downstream holds for 10 cycles mid-stream on ch2.
    fork
      begin
        for (int n = 0; n < 20; n++) send(2, (n == 0) ? 16'h4000 : 0);
      end
      begin
        repeat (6) @(posedge clock);
        #1;
        out_ready = 1'b0;
        @(negedge clock);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        repeat (10) @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    join
    for (int n = 0; n < 20; n++)
      expect_out($sformatf("bp%0d", n), 2, (n + 2) / 2, 0);
    expect_no_more("bp_extra");

    // Commit mid-stream on ch3: old set before, 0x7FFF after, sums kept.
    load_coefs(1);
    for (int n = 0; n < 5; n++) send(3, (n == 0) ? 16'h4000 : 0);
    commit("commit1");
    send(3, 16'h4000);
    send(3, 0);
    send(3, 0);
    for (int n = 0; n < 8; n++)
      expect_out($sformatf("cm%0d", n), 3, ((n + 1) + ((n >= 5) ? 32767 : 0) + 1) / 2, 0);
    expect_no_more("cm_extra");

    // Reset with S1..S4 full: in-flight samples vanish.
    in_valid   = 1'b1;
    in_data    = 16'sh1234;
    in_channel = 2'd2;
    repeat (6) @(posedge clock);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_coef_busy", coef_busy, 0);
    chk("mrst_in_ready", in_ready, 1);
    q_data.delete();
    q_ch.delete();
    q_ovf.delete();
    expect_no_more("mrst_no_output");

    // Clean post-reset impulse on ch1 with all-0x7FFF taps: 0x4000 per output.
    load_coefs(1);
    commit("commit2");
    send(1, 16'h4000);
    for (int n = 1; n < 4; n++) send(1, 0);
    for (int n = 0; n < 4; n++)
      expect_out($sformatf("post_rst%0d", n), 1, 16384, 0);
    expect_no_more("post_rst_extra");

    // Saturation: x=0x7FFF steady on clean ch0, all taps 0x7FFF.
    for (int n = 0; n < 3; n++) send(0, 16'h7FFF);
    expect_out("sat0", 0, 32766, 0);
`ifdef FIR_SATURATION_EN
    expect_out("sat1", 0, 32767, 1);
    expect_out("sat2", 0, 32767, 1);
`else
    expect_out("sat1", 0, -4, 0);
    expect_out("sat2", 0, 32762, 0);
`endif
    expect_no_more("sat_extra");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
